// File: rtl/pep_bpip_batch_ctrl.sv
// Batch launcher for the PEP pipeline.
// Counts accepted PBS commands and decides when to launch a batch: when the batch is full,
// when the fill timer expires, opportunistically, or immediately when batching is disabled.
// The frozen batch size and cause are handed to the sequencer over a valid/ready handshake.
module pep_bpip_batch_ctrl #(
  parameter int unsigned BATCH_PBS_NB  = 12,
  parameter int unsigned TIMEOUT_CNT_W = 32,
  parameter int unsigned CNT_W         = $clog2(BATCH_PBS_NB + 1)
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic                     use_bpip,
  input  logic                     use_bpip_opportunism,
  input  logic [TIMEOUT_CNT_W-1:0] bpip_timeout,
  input  logic                     in_pbs_vld,
  output logic                     in_pbs_rdy,
  input  logic                     batch_busy,
  output logic                     launch_vld,
  input  logic                     launch_rdy,
  output logic [CNT_W-1:0]         launch_nb,
  output logic [1:0]               launch_cause,
  output logic [CNT_W-1:0]         pending_cnt
);

  localparam logic [1:0] CauseFull    = 2'd0;
  localparam logic [1:0] CauseTimeout = 2'd1;
  localparam logic [1:0] CauseOpport  = 2'd2;
  localparam logic [1:0] CauseNoBpip  = 2'd3;

  localparam logic [CNT_W-1:0] PendingMax = CNT_W'(BATCH_PBS_NB);

  typedef enum logic [1:0] {StIdle, StFill, StLaunch} state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         pending_q;
  logic [TIMEOUT_CNT_W-1:0] timer_q;
  logic                     launch_vld_q;
  logic [CNT_W-1:0]         launch_nb_q;
  logic [1:0]               launch_cause_q;

  logic                     in_accept;
  logic [CNT_W-1:0]         pending_inc;
  logic [CNT_W-1:0]         pending_post;
  logic [TIMEOUT_CNT_W-1:0] timer_inc;
  logic                     is_full;
  logic                     is_timeout;
  logic                     go;
  logic [1:0]               cause_d;

  // Accept handshake, launch decision and cause priority.
  always_comb begin
    in_pbs_rdy   = (state_q != StLaunch) && (pending_q < PendingMax);
    in_accept    = in_pbs_vld && in_pbs_rdy;
    pending_inc  = pending_q + CNT_W'(1);
    pending_post = in_accept ? pending_inc : pending_q;
    // Timer saturates at all-ones so a long busy wait cannot wrap back below the timeout.
    timer_inc    = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_CNT_W'(1);
    is_full      = (pending_q == PendingMax);
    is_timeout   = (timer_q >= bpip_timeout);
    go           = !batch_busy && (!use_bpip || is_full || is_timeout || use_bpip_opportunism);
    cause_d      = CauseOpport;
    if (!use_bpip) begin
      cause_d = CauseNoBpip;
    end else if (is_full) begin
      cause_d = CauseFull;
    end else if (is_timeout) begin
      cause_d = CauseTimeout;
    end
  end

  // Batch FSM with registered launch outputs.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      timer_q        <= '0;
      launch_vld_q   <= 1'b0;
      launch_nb_q    <= '0;
      launch_cause_q <= CauseFull;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (in_accept) begin
            pending_q <= pending_inc;
            state_q   <= StFill;
          end
        end
        StFill: begin
          timer_q   <= timer_inc;
          pending_q <= pending_post;
          if (go) begin
            // A command accepted in the launch cycle joins this batch.
            state_q        <= StLaunch;
            launch_vld_q   <= 1'b1;
            launch_nb_q    <= pending_post;
            launch_cause_q <= cause_d;
          end
        end
        StLaunch: begin
          // Request is held until the sequencer takes it, whatever batch_busy does.
          if (launch_rdy) begin
            state_q      <= StIdle;
            launch_vld_q <= 1'b0;
            pending_q    <= '0;
            timer_q      <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign launch_vld   = launch_vld_q;
  assign launch_nb    = launch_nb_q;
  assign launch_cause = launch_cause_q;
  assign pending_cnt  = pending_q;

endmodule

// File: tb/tb_pep_bpip_batch_ctrl.sv
// Directed bench for pep_bpip_batch_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_pep_bpip_batch_ctrl;

  localparam int unsigned BATCH_PBS_NB  = 12;
  localparam int unsigned TIMEOUT_CNT_W = 32;
  localparam int unsigned CNT_W         = $clog2(BATCH_PBS_NB + 1);

  logic                     clk = 1'b0;
  logic                     a_rst = 1'b0;
  logic                     use_bpip = 1'b0;
  logic                     use_bpip_opportunism = 1'b0;
  logic [TIMEOUT_CNT_W-1:0] bpip_timeout = '0;
  logic                     in_pbs_vld = 1'b0;
  logic                     in_pbs_rdy;
  logic                     batch_busy = 1'b0;
  logic                     launch_vld;
  logic                     launch_rdy = 1'b0;
  logic [CNT_W-1:0]         launch_nb;
  logic [1:0]               launch_cause;
  logic [CNT_W-1:0]         pending_cnt;

  int n_total = 0;
  int n_bad   = 0;

  pep_bpip_batch_ctrl #(
    .BATCH_PBS_NB (BATCH_PBS_NB),
    .TIMEOUT_CNT_W(TIMEOUT_CNT_W)
  ) dut (
    .clk                 (clk),
    .a_rst               (a_rst),
    .use_bpip            (use_bpip),
    .use_bpip_opportunism(use_bpip_opportunism),
    .bpip_timeout        (bpip_timeout),
    .in_pbs_vld          (in_pbs_vld),
    .in_pbs_rdy          (in_pbs_rdy),
    .batch_busy          (batch_busy),
    .launch_vld          (launch_vld),
    .launch_rdy          (launch_rdy),
    .launch_nb           (launch_nb),
    .launch_cause        (launch_cause),
    .pending_cnt         (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    step(2);
    a_rst = 1'b0;
    step(1);
  endtask

  // Complete the handshake on a pending launch and return to idle.
  task automatic handshake();
    launch_rdy = 1'b1;
    step(1);
    launch_rdy = 1'b0;
  endtask

  initial begin
    // Reset state.
    a_rst = 1'b1;
    #3;
    check_eq("rst_vld", 32'(launch_vld), 0);
    check_eq("rst_pend", 32'(pending_cnt), 0);
    check_eq("rst_nb", 32'(launch_nb), 0);
    check_eq("rst_cause", 32'(launch_cause), 0);
    check_eq("rst_inrdy", 32'(in_pbs_rdy), 1);
    step(1);
    a_rst = 1'b0;
    step(1);

    // No BPIP: one command at cycle 0, launch at cycle 2, idle at cycle 3.
    use_bpip   = 1'b0;
    in_pbs_vld = 1'b1;
    step(1);
    in_pbs_vld = 1'b0;
    check_eq("nob_c1_pend", 32'(pending_cnt), 1);
    check_eq("nob_c1_vld", 32'(launch_vld), 0);
    step(1);
    check_eq("nob_c2_vld", 32'(launch_vld), 1);
    check_eq("nob_c2_nb", 32'(launch_nb), 1);
    check_eq("nob_c2_cause", 32'(launch_cause), 3);
    check_eq("nob_c2_inrdy", 32'(in_pbs_rdy), 0);
    handshake();
    check_eq("nob_c3_vld", 32'(launch_vld), 0);
    check_eq("nob_c3_pend", 32'(pending_cnt), 0);
    check_eq("nob_c3_inrdy", 32'(in_pbs_rdy), 1);

    // No BPIP, accept in the launch cycle joins the batch.
    in_pbs_vld = 1'b1;
    step(2);
    in_pbs_vld = 1'b0;
    check_eq("join_vld", 32'(launch_vld), 1);
    check_eq("join_nb", 32'(launch_nb), 2);
    check_eq("join_pend", 32'(pending_cnt), 2);
    handshake();

    // Full batch: 12 back-to-back commands, 13th stalls, launch held without ready.
    use_bpip             = 1'b1;
    use_bpip_opportunism = 1'b0;
    bpip_timeout         = 32'd1000;
    in_pbs_vld           = 1'b1;
    step(12);
    check_eq("full_c12_pend", 32'(pending_cnt), 12);
    check_eq("full_c12_inrdy", 32'(in_pbs_rdy), 0);
    check_eq("full_c12_vld", 32'(launch_vld), 0);
    step(1);
    check_eq("full_c13_vld", 32'(launch_vld), 1);
    check_eq("full_c13_nb", 32'(launch_nb), 12);
    check_eq("full_c13_cause", 32'(launch_cause), 0);
    // Config change during launch must not disturb the frozen outputs.
    use_bpip = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_eq("hold_vld", 32'(launch_vld), 1);
      check_eq("hold_nb", 32'(launch_nb), 12);
      check_eq("hold_cause", 32'(launch_cause), 0);
      check_eq("hold_inrdy", 32'(in_pbs_rdy), 0);
      check_eq("hold_pend", 32'(pending_cnt), 12);
    end
    use_bpip = 1'b1;
    handshake();
    check_eq("resume_inrdy", 32'(in_pbs_rdy), 1);
    check_eq("resume_pend0", 32'(pending_cnt), 0);
    step(1);
    in_pbs_vld = 1'b0;
    check_eq("resume_pend1", 32'(pending_cnt), 1);
    do_reset();

    // Timeout = 20, three commands: launch at cycle 22.
    use_bpip     = 1'b1;
    bpip_timeout = 32'd20;
    in_pbs_vld   = 1'b1;
    step(3);
    in_pbs_vld = 1'b0;
    step(18);
    check_eq("to_c21_vld", 32'(launch_vld), 0);
    step(1);
    check_eq("to_c22_vld", 32'(launch_vld), 1);
    check_eq("to_c22_nb", 32'(launch_nb), 3);
    check_eq("to_c22_cause", 32'(launch_cause), 1);
    handshake();
    check_eq("to_idle_vld", 32'(launch_vld), 0);

    // Timeout = 0: launch at cycle 2.
    bpip_timeout = 32'd0;
    in_pbs_vld   = 1'b1;
    step(1);
    in_pbs_vld = 1'b0;
    check_eq("to0_c1_vld", 32'(launch_vld), 0);
    step(1);
    check_eq("to0_c2_vld", 32'(launch_vld), 1);
    check_eq("to0_c2_cause", 32'(launch_cause), 1);
    handshake();

    // Opportunism held off by busy for 50 cycles.
    bpip_timeout         = 32'd1000;
    use_bpip_opportunism = 1'b1;
    batch_busy           = 1'b1;
    in_pbs_vld           = 1'b1;
    step(2);
    in_pbs_vld = 1'b0;
    for (int c = 2; c < 50; c++) begin
      if (launch_vld !== 1'b0) check_eq("busy_vld", 32'(launch_vld), 0);
      step(1);
    end
    check_eq("busy_c50_vld", 32'(launch_vld), 0);
    check_eq("busy_c50_pend", 32'(pending_cnt), 2);
    batch_busy = 1'b0;
    step(1);
    check_eq("opp_vld", 32'(launch_vld), 1);
    check_eq("opp_nb", 32'(launch_nb), 2);
    check_eq("opp_cause", 32'(launch_cause), 2);
    // Busy rising during launch must not withdraw the request.
    batch_busy = 1'b1;
    step(1);
    check_eq("opp_busy_vld", 32'(launch_vld), 1);
    handshake();
    batch_busy           = 1'b0;
    use_bpip_opportunism = 1'b0;

    // Async reset mid-launch with five pending commands.
    in_pbs_vld = 1'b1;
    step(5);
    in_pbs_vld = 1'b0;
    check_eq("rl_c5_pend", 32'(pending_cnt), 5);
    check_eq("rl_c5_vld", 32'(launch_vld), 0);
    use_bpip = 1'b0;
    step(1);
    check_eq("rl_vld", 32'(launch_vld), 1);
    check_eq("rl_nb", 32'(launch_nb), 5);
    #2;
    a_rst = 1'b1;
    #1;
    check_eq("rl_async_vld", 32'(launch_vld), 0);
    check_eq("rl_async_pend", 32'(pending_cnt), 0);
    step(1);
    a_rst = 1'b0;
    step(1);
    check_eq("rl_after_inrdy", 32'(in_pbs_rdy), 1);
    check_eq("rl_after_vld", 32'(launch_vld), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
